// File: rtl/add_sub_pipe.sv
// add_sub_pipe: two-stage, multi-lane add/subtract with valid/ready on both sides.
// Lanes are IEEE-style floating point (ARITH_TYPE=0) or wrapping two's-complement fixed point (ARITH_TYPE=1).
module add_sub_pipe #(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int INTEGER    = 12,
    parameter int FRACTION   = 20,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_sub,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_ovf
);
    localparam int FXW  = INTEGER + FRACTION;
    localparam int FW   = M + 4;
    localparam int EMAX = (1 << E) - 1;

    // Significands carry guard, round and sticky bits below the LSB; rounding is nearest-even.
    function automatic logic [DATA_WIDTH-1:0] fp_add(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] x, y, res;
        logic [E-1:0] ex_x, ex_y;
        logic [M:0] fx, fy;
        logic [FW-1:0] big, sm;
        logic [FW:0] acc;
        logic [M+1:0] rnd;
        logic sticky, up;
        int xa, xb, d, ex;
        x = a;
        y = b;
        if (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) begin
            x = b;
            y = a;
        end
        ex_x = x[DATA_WIDTH-2:M];
        ex_y = y[DATA_WIDTH-2:M];
        fx = {ex_x != '0, x[M-1:0]};
        fy = {ex_y != '0, y[M-1:0]};
        xa = (ex_x == '0) ? 1 : int'(ex_x);
        xb = (ex_y == '0) ? 1 : int'(ex_y);
        d = xa - xb;
        big = {fx, 3'b000};
        sm = {fy, 3'b000};
        if (d >= FW) begin
            sticky = |fy;
            sm = '0;
        end else begin
            sticky = |(sm & ~({FW{1'b1}} << d));
            sm = sm >> d;
        end
        sm[0] = sm[0] | sticky;
        acc = (x[DATA_WIDTH-1] == y[DATA_WIDTH-1]) ? {1'b0, big} + {1'b0, sm} : {1'b0, big} - {1'b0, sm};
        ex = xa;
        if (acc[FW]) begin
            acc = {1'b0, acc[FW:2], acc[1] | acc[0]};
            ex = ex + 1;
        end
        // Left-normalise, stopping at the minimum exponent so tiny results stay subnormal.
        for (int i = 0; i < FW; i++) begin
            if (!acc[FW-1] && ex > 1) begin
                acc = acc << 1;
                ex = ex - 1;
            end
        end
        up = acc[2] && (acc[1] || acc[0] || acc[3]);
        rnd = {1'b0, acc[FW-1:3]} + {{(M+1){1'b0}}, up};
        if (rnd[M+1]) begin
            rnd = rnd >> 1;
            ex = ex + 1;
        end
        res = (ex >= EMAX) ? {x[DATA_WIDTH-1], {E{1'b1}}, {M{1'b0}}}
                           : {x[DATA_WIDTH-1], rnd[M] ? ex[E-1:0] : {E{1'b0}}, rnd[M-1:0]};
        if (acc == '0) res = {x[DATA_WIDTH-1] & y[DATA_WIDTH-1], {(DATA_WIDTH-1){1'b0}}};
        // x has the larger magnitude, so any NaN or infinity operand shows up in x.
        if (&ex_x)
            res = ((|x[M-1:0]) || (&ex_y && x[DATA_WIDTH-1] != y[DATA_WIDTH-1]))
                  ? {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} : x;
        return res;
    endfunction

    // Exact one-bit-wider signed result: low bits wrap, top two bits disagree on overflow.
    function automatic logic [FXW:0] fx_add(input logic [FXW-1:0] a, input logic [FXW-1:0] b, input logic sub);
        logic [FXW:0] s;
        s = sub ? {a[FXW-1], a} - {b[FXW-1], b} : {a[FXW-1], a} + {b[FXW-1], b};
        return {s[FXW] ^ s[FXW-1], s[FXW-1:0]};
    endfunction

    logic                        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [LANES*DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d, lane_res;
    logic [LANES-1:0]            sub_q, sub_d, ovf_q, ovf_d, lane_ovf;
    logic                        adv, accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a, b;
        assign a = a_q[i*DATA_WIDTH +: DATA_WIDTH];
        assign b = b_q[i*DATA_WIDTH +: DATA_WIDTH];
        if (ARITH_TYPE == 0) begin : g_fp
            assign lane_res[i*DATA_WIDTH +: DATA_WIDTH] = fp_add(a, {b[DATA_WIDTH-1] ^ sub_q[i], b[DATA_WIDTH-2:0]});
            assign lane_ovf[i] = 1'b0;
        end else begin : g_fx
            assign {lane_ovf[i], lane_res[i*DATA_WIDTH +: DATA_WIDTH]} = fx_add(a, b, sub_q[i]);
        end
    end

    always_comb begin
        adv = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || adv;
        accept = in_valid && in_ready;
        s1_valid_d = accept || (s1_valid_q && !adv);
        a_d = accept ? in_a : a_q;
        b_d = accept ? in_b : b_q;
        sub_d = accept ? in_sub : sub_q;
        s2_valid_d = adv ? s1_valid_q : s2_valid_q;
        data_d = (adv && s1_valid_q) ? lane_res : data_q;
        ovf_d = (adv && s1_valid_q) ? lane_ovf : ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            sub_q <= '0;
            data_q <= '0;
            ovf_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q <= a_d;
            b_q <= b_d;
            sub_q <= sub_d;
            data_q <= data_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data = data_q;
    assign out_ovf = ovf_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: directed vectors on fixed (2 lanes, 1 lane) and float (2 lanes) pipes
// sharing one handshake stream; covers latency, stall, streaming and mid-stream reset.
module tb_add_sub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [1:0]  in_sub;
    logic [63:0] in_a, in_b;
    logic        fx_rdy, fx_vld, fp_rdy, fp_vld, f1_rdy, f1_vld;
    logic [63:0] fx_data, fp_data;
    logic [31:0] f1_data;
    logic [1:0]  fx_ovf, fp_ovf;
    logic [0:0]  f1_ovf;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    add_sub_pipe #(.ARITH_TYPE(1), .LANES(2)) u_fx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fx_rdy), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(fx_vld), .out_ready(out_ready),
        .out_data(fx_data), .out_ovf(fx_ovf));

    add_sub_pipe #(.ARITH_TYPE(0), .LANES(2)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fp_rdy), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .out_valid(fp_vld), .out_ready(out_ready),
        .out_data(fp_data), .out_ovf(fp_ovf));

    add_sub_pipe #(.ARITH_TYPE(1), .LANES(1)) u_f1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(f1_rdy), .in_sub(in_sub[0:0]),
        .in_a(in_a[31:0]), .in_b(in_b[31:0]), .out_valid(f1_vld), .out_ready(out_ready),
        .out_data(f1_data), .out_ovf(f1_ovf));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction with out_ready=1: not visible one cycle after acceptance, visible the next.
    task automatic run_vec(input string tag, input logic [1:0] sub, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] fx, input logic [1:0] ov, input logic [63:0] fp, input bit use_fp);
        @(negedge clk);
        in_valid = 1'b1;
        in_sub = sub;
        in_a = a;
        in_b = b;
        #1 check({tag, "_rdy"}, fx_rdy, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_early"}, fx_vld, 1'b0);
        @(negedge clk);
        check({tag, "_vld"}, fx_vld, 1'b1);
        check({tag, "_fx"}, fx_data, fx);
        check({tag, "_ovf"}, fx_ovf, ov);
        check({tag, "_f1"}, f1_data, fx[31:0]);
        check({tag, "_f1ovf"}, f1_ovf, ov[0]);
        check({tag, "_fpvld"}, fp_vld, 1'b1);
        check({tag, "_fpovf"}, fp_ovf, 2'b00);
        if (use_fp) check({tag, "_fp"}, fp_data, fp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_sub = 2'b00;
        in_a = 64'h0000_0001_0000_0001;
        in_b = 64'h0000_0001_0000_0001;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_vld", fx_vld, 1'b0);
        check("rst_rdy", fx_rdy, 1'b1);
        check("rst_data", fx_data, 64'h0);
        check("rst_ovf", fx_ovf, 2'b00);
        check("rst_fpdata", fp_data, 64'h0);
        @(negedge clk);
        check("rst_vld2", fx_vld, 1'b0);

        run_vec("v0", 2'b00, 64'h7FFFFFFF_00100000, 64'h00000001_00080000, 64'h80000000_00180000, 2'b10, 64'h0, 1'b0);
        run_vec("v1", 2'b11, 64'h80000000_00000000, 64'h00000001_80000000, 64'h7FFFFFFF_80000000, 2'b11, 64'h0, 1'b0);
        run_vec("v2", 2'b10, 64'h00000005_FFFFFFFF, 64'h00000003_00000001, 64'h00000002_00000000, 2'b00, 64'h0, 1'b0);
        run_vec("v3", 2'b10, 64'h3F800000_3F800000, 64'h40000000_40000000, 64'hFF800000_7F800000, 2'b00, 64'hBF800000_40400000, 1'b1);
        run_vec("v4", 2'b00, 64'hC0400000_3FC00000, 64'h40400000_3FC00000, 64'h00800000_7F800000, 2'b00, 64'h00000000_40400000, 1'b1);
        run_vec("v5", 2'b10, 64'h3F800000_3F800000, 64'h3FC00000_33800000, 64'hFFC00000_73000000, 2'b00, 64'hBF000000_3F800000, 1'b1);
        run_vec("v6", 2'b00, 64'h7F7FFFFF_00000001, 64'h7F7FFFFF_00000001, 64'hFEFFFFFE_00000002, 2'b10, 64'h7F800000_00000002, 1'b1);

        // Ten back-to-back transactions, results expected on ten consecutive cycles.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 12) begin
                check("strm_vld", fx_vld, 1'b1);
                check("strm_data", fx_data, {32'(2 * (k - 2)), 32'(k - 2 + 100)});
            end else begin
                check("strm_idle", fx_vld, 1'b0);
            end
            in_valid = (k < 10);
            in_sub = 2'b00;
            in_a = {32'(k), 32'(k)};
            in_b = {32'(k), 32'd100};
        end
        in_valid = 1'b0;

        // Stall: downstream blocked for five cycles while the source keeps offering.
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 2) check("stall_hold", fx_data, 64'h00000000_00000011);
            in_valid = 1'b1;
            in_sub = 2'b00;
            in_a = {32'd0, 32'(16 + acc)};
            in_b = {32'd0, 32'd1};
            #1 if (fx_rdy) acc++;
        end
        @(negedge clk);
        check("stall_acc", acc, 2);
        check("stall_rdy", fx_rdy, 1'b0);
        check("stall_vld", fx_vld, 1'b1);
        check("stall_d0", fx_data, 64'h00000000_00000011);
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_vld", fx_vld, 1'b1);
        check("rel_d1", fx_data, 64'h00000000_00000012);
        @(negedge clk);
        check("rel_empty", fx_vld, 1'b0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 64'h00000001_00000002;
        in_b = 64'h00000003_00000004;
        @(negedge clk);
        in_a = 64'h00000005_00000006;
        @(negedge clk);
        @(negedge clk);
        check("full_vld", fx_vld, 1'b1);
        check("full_rdy", fx_rdy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mrst_vld", fx_vld, 1'b0);
        check("mrst_rdy", fx_rdy, 1'b1);
        check("mrst_data", fx_data, 64'h0);
        check("mrst_ovf", fx_ovf, 2'b00);
        check("mrst_fpvld", fp_vld, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("mrst_stale", fx_vld, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
